// File: rtl/game_tick_scheduler.sv
// Purpose : single-clock timebase; one-cycle enable strobes plus IDLE/RUN/PAUSE/DONE game-time sequencing.
// Latency : all outputs registered; a control pulse sampled at edge E takes effect on outputs after E.
// Backpr. : none; control inputs are single-cycle pulses, strobes are consumed as clock enables.
//
// Ports:
//    clk, rst               master clock, asynchronous active-high reset
//    start, pause_toggle,   control pulses (priority clear > start > pause_toggle)
//    clear
//    pix_en, seg_en         free-running strobes (every PIX_DIV / SEG_DIV cycles)
//    char_en, sec_en        strobes that advance only while running
//    running, paused, done  one-hot view of the game state (all low in IDLE)
//    time_left              seconds remaining, time_up pulses when it reaches 0
module game_tick_scheduler #(
   parameter int PIX_DIV      = 4,
   parameter int SEG_DIV      = 200000,
   parameter int CHAR_DIV     = 10000000,
   parameter int SEC_DIV      = 100000000,
   parameter int GAME_SECONDS = 180,
   parameter int SEC_W        = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             pause_toggle,
   input  logic             clear,
   output logic             pix_en,
   output logic             seg_en,
   output logic             char_en,
   output logic             sec_en,
   output logic             running,
   output logic             paused,
   output logic             done,
   output logic [SEC_W-1:0] time_left,
   output logic             time_up
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

   localparam logic [31:0]      PIX_LAST  = 32'(PIX_DIV - 1);
   localparam logic [31:0]      SEG_LAST  = 32'(SEG_DIV - 1);
   localparam logic [31:0]      CHAR_LAST = 32'(CHAR_DIV - 1);
   localparam logic [31:0]      SEC_LAST  = 32'(SEC_DIV - 1);
   localparam logic [SEC_W-1:0] TL_LOAD   = SEC_W'(GAME_SECONDS);
   localparam logic [SEC_W-1:0] TL_ONE    = SEC_W'(1);

   state_t           state_q, state_d;
   logic [31:0]      pix_cnt_q, pix_cnt_d;
   logic [31:0]      seg_cnt_q, seg_cnt_d;
   logic [31:0]      char_cnt_q, char_cnt_d;
   logic [31:0]      sec_cnt_q, sec_cnt_d;
   logic             pix_en_q, pix_en_d;
   logic             seg_en_q, seg_en_d;
   logic             char_en_q, char_en_d;
   logic             sec_en_q, sec_en_d;
   logic             time_up_q, time_up_d;
   logic [SEC_W-1:0] time_left_q, time_left_d;
   logic             running_q, paused_q, done_q;

   logic char_wrap, sec_wrap, last_second;

   assign char_wrap   = (char_cnt_q == CHAR_LAST);
   assign sec_wrap    = (sec_cnt_q == SEC_LAST);
   assign last_second = sec_wrap && (time_left_q == TL_ONE);

   // Display dividers run in every state so the screen keeps refreshing.
   always_comb begin
      pix_en_d  = (pix_cnt_q == PIX_LAST);
      pix_cnt_d = pix_en_d ? 32'd0 : pix_cnt_q + 32'd1;
      seg_en_d  = (seg_cnt_q == SEG_LAST);
      seg_cnt_d = seg_en_d ? 32'd0 : seg_cnt_q + 32'd1;
   end

   // Game state machine and the gated char/sec dividers.
   always_comb begin
      state_d     = state_q;
      time_left_d = time_left_q;
      char_cnt_d  = char_cnt_q;
      sec_cnt_d   = sec_cnt_q;
      char_en_d   = 1'b0;
      sec_en_d    = 1'b0;
      time_up_d   = 1'b0;

      if (clear) begin
         state_d     = S_IDLE;
         time_left_d = TL_LOAD;
         char_cnt_d  = 32'd0;
         sec_cnt_d   = 32'd0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               char_cnt_d = 32'd0;
               sec_cnt_d  = 32'd0;
               if (start) begin
                  state_d     = S_RUN;
                  time_left_d = TL_LOAD;
               end
            end
            S_RUN: begin
               char_en_d  = char_wrap;
               char_cnt_d = char_wrap ? 32'd0 : char_cnt_q + 32'd1;
               sec_en_d   = sec_wrap;
               sec_cnt_d  = sec_wrap ? 32'd0 : sec_cnt_q + 32'd1;
               if (last_second) begin
                  time_left_d = '0;
                  time_up_d   = 1'b1;
                  state_d     = S_DONE;
               end else begin
                  if (sec_wrap) begin
                     time_left_d = time_left_q - TL_ONE;
                  end
                  // A pause coinciding with a normal tick still lets the tick land.
                  if (pause_toggle) begin
                     state_d = S_PAUSE;
                  end
               end
            end
            S_PAUSE: begin
               // Counters hold so the remaining fraction of a second is preserved.
               if (pause_toggle) begin
                  state_d = S_RUN;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         pix_cnt_q   <= 32'd0;
         seg_cnt_q   <= 32'd0;
         char_cnt_q  <= 32'd0;
         sec_cnt_q   <= 32'd0;
         pix_en_q    <= 1'b0;
         seg_en_q    <= 1'b0;
         char_en_q   <= 1'b0;
         sec_en_q    <= 1'b0;
         time_up_q   <= 1'b0;
         time_left_q <= TL_LOAD;
         running_q   <= 1'b0;
         paused_q    <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pix_cnt_q   <= pix_cnt_d;
         seg_cnt_q   <= seg_cnt_d;
         char_cnt_q  <= char_cnt_d;
         sec_cnt_q   <= sec_cnt_d;
         pix_en_q    <= pix_en_d;
         seg_en_q    <= seg_en_d;
         char_en_q   <= char_en_d;
         sec_en_q    <= sec_en_d;
         time_up_q   <= time_up_d;
         time_left_q <= time_left_d;
         running_q   <= (state_d == S_RUN);
         paused_q    <= (state_d == S_PAUSE);
         done_q      <= (state_d == S_DONE);
      end
   end

   assign pix_en    = pix_en_q;
   assign seg_en    = seg_en_q;
   assign char_en   = char_en_q;
   assign sec_en    = sec_en_q;
   assign time_up   = time_up_q;
   assign time_left = time_left_q;
   assign running   = running_q;
   assign paused    = paused_q;
   assign done      = done_q;

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Purpose : self-checking bench for game_tick_scheduler against an elapsed-time reference model.
// Latency : outputs sampled 1 time unit after each rising edge.
// Backpr. : not applicable.
module tb_game_tick_scheduler;

   localparam int PIX_DIV  = 4;
   localparam int SEG_DIV  = 5;
   localparam int CHAR_DIV = 3;
   localparam int SEC_DIV  = 10;
   localparam int GAME     = 3;
   localparam int SEC_W    = 8;

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_PAUSE = 2;
   localparam int M_DONE  = 3;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             start = 1'b0;
   logic             pause_toggle = 1'b0;
   logic             clear = 1'b0;
   logic             pix_en, seg_en, char_en, sec_en;
   logic             running, paused, done, time_up;
   logic [SEC_W-1:0] time_left;

   game_tick_scheduler #(
      .PIX_DIV(PIX_DIV), .SEG_DIV(SEG_DIV), .CHAR_DIV(CHAR_DIV),
      .SEC_DIV(SEC_DIV), .GAME_SECONDS(GAME), .SEC_W(SEC_W)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .pause_toggle(pause_toggle), .clear(clear),
      .pix_en(pix_en), .seg_en(seg_en), .char_en(char_en), .sec_en(sec_en),
      .running(running), .paused(paused), .done(done),
      .time_left(time_left), .time_up(time_up)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: game progress is tracked as elapsed running cycles since start.
   int m_mode    = M_IDLE;
   int m_elapsed = 0;
   int m_edges   = 0;
   bit e_pix, e_seg, e_char, e_sec, e_tu, e_dc;
   int e_tl = GAME;

   function automatic logic [15:0] obs_vec();
      return {pix_en, seg_en, char_en, sec_en, running, paused, done, time_up, time_left};
   endfunction

   function automatic logic [15:0] exp_vec();
      logic [7:0] tl;
      tl = 8'(e_tl);
      return {e_pix, e_seg, e_char, e_sec, m_mode == M_RUN, m_mode == M_PAUSE,
              m_mode == M_DONE, e_tu, tl};
   endfunction

   // Strobe bits are not judged on the edge that samples clear.
   function automatic logic [15:0] msk();
      return e_dc ? 16'hCFFF : 16'hFFFF;
   endfunction

   task automatic model_reset();
      m_mode = M_IDLE; m_elapsed = 0; m_edges = 0;
      e_pix = 0; e_seg = 0; e_char = 0; e_sec = 0; e_tu = 0; e_dc = 0; e_tl = GAME;
   endtask

   // Drive one cycle of inputs, advance one edge, update the model, settle.
   task automatic tick(input bit s, input bit p, input bit c);
      start = s; pause_toggle = p; clear = c;
      @(posedge clk);
      m_edges++;
      e_pix = (m_edges % PIX_DIV) == 0;
      e_seg = (m_edges % SEG_DIV) == 0;
      e_char = 0; e_sec = 0; e_tu = 0; e_dc = 0;
      if (c) begin
         m_mode = M_IDLE; m_elapsed = 0; e_dc = 1;
      end else begin
         case (m_mode)
            M_IDLE, M_DONE: if (s) begin m_mode = M_RUN; m_elapsed = 0; end
            M_RUN: begin
               m_elapsed++;
               e_char = (m_elapsed % CHAR_DIV) == 0;
               e_sec  = (m_elapsed % SEC_DIV) == 0;
               if (GAME - m_elapsed / SEC_DIV == 0) begin
                  e_tu = 1; m_mode = M_DONE;
               end else if (p) begin
                  m_mode = M_PAUSE;
               end
            end
            M_PAUSE: if (p) m_mode = M_RUN;
            default: m_mode = M_IDLE;
         endcase
      end
      e_tl = (m_mode == M_IDLE) ? GAME : (m_mode == M_DONE) ? 0 : GAME - m_elapsed / SEC_DIV;
      #1;
      start = 0; pause_toggle = 0; clear = 0;
   endtask

   task automatic test_reset();
      rst = 1;
      #2;
      n_checks++;
      if (obs_vec() !== {8'b0, 8'(GAME)}) begin
         n_fail++; $display("FAIL reset_async obs=%h exp=%h", obs_vec(), {8'b0, 8'(GAME)});
      end
      @(posedge clk); @(posedge clk); #1;
      n_checks++;
      if (obs_vec() !== {8'b0, 8'(GAME)}) begin
         n_fail++; $display("FAIL reset_held obs=%h exp=%h", obs_vec(), {8'b0, 8'(GAME)});
      end
      rst = 0;
      model_reset();
   endtask

   task automatic test_idle();
      int npix = 0, nseg = 0, nother = 0;
      for (int i = 0; i < 40; i++) begin
         tick(0, 0, 0);
         n_checks++;
         if ((obs_vec() & msk()) !== (exp_vec() & msk())) begin
            n_fail++; $display("FAIL idle cyc=%0d obs=%h exp=%h", i, obs_vec(), exp_vec());
         end
         npix += int'(pix_en); nseg += int'(seg_en); nother += int'(char_en | sec_en | running);
      end
      n_checks++;
      if (npix !== 10 || nseg !== 8 || nother !== 0) begin
         n_fail++; $display("FAIL idle_counts pix=%0d seg=%0d other=%0d exp 10 8 0", npix, nseg, nother);
      end
   endtask

   task automatic test_countdown(input string name);
      int secq[$];
      int ntu = 0;
      tick(1, 0, 0);
      n_checks++;
      if (running !== 1'b1 || time_left !== 8'(GAME)) begin
         n_fail++; $display("FAIL %s_start running=%b tl=%0d exp 1 %0d", name, running, time_left, GAME);
      end
      for (int e = 1; e <= 40; e++) begin
         tick(0, 0, 0);
         n_checks++;
         if ((obs_vec() & msk()) !== (exp_vec() & msk())) begin
            n_fail++; $display("FAIL %s cyc=%0d obs=%h exp=%h", name, e, obs_vec(), exp_vec());
         end
         if (sec_en) secq.push_back(e);
         ntu += int'(time_up);
      end
      n_checks++;
      if (secq.size() != 3 || secq[0] != 10 || secq[1] != 20 || secq[2] != 30 || ntu != 1) begin
         n_fail++; $display("FAIL %s_sec_edges count=%0d time_up=%0d exp edges 10,20,30 and 1", name, secq.size(), ntu);
      end
      n_checks++;
      if (done !== 1'b1 || time_left !== 8'd0) begin
         n_fail++; $display("FAIL %s_done done=%b tl=%0d exp 1 0", name, done, time_left);
      end
   endtask

   task automatic test_pause();
      int first_sec = -1;
      int npaused = 0;
      tick(1, 0, 0);
      for (int e = 1; e <= 35; e++) begin
         tick(0, (e == 4) || (e == 24), 0);
         n_checks++;
         if ((obs_vec() & msk()) !== (exp_vec() & msk())) begin
            n_fail++; $display("FAIL pause cyc=%0d obs=%h exp=%h", e, obs_vec(), exp_vec());
         end
         if (sec_en && first_sec < 0) first_sec = e;
         npaused += int'(paused);
      end
      n_checks++;
      if (first_sec !== 30 || npaused !== 20) begin
         n_fail++; $display("FAIL pause_delay first_sec=%0d paused_cycles=%0d exp 30 20", first_sec, npaused);
      end
      tick(0, 0, 1);
   endtask

   task automatic test_pause_on_tick();
      tick(1, 0, 0);
      for (int e = 1; e <= 9; e++) tick(0, 0, 0);
      tick(0, 1, 0);
      n_checks++;
      if (sec_en !== 1'b1 || time_left !== 8'd2 || paused !== 1'b1 || running !== 1'b0) begin
         n_fail++; $display("FAIL pause_on_tick sec=%b tl=%0d paused=%b running=%b exp 1 2 1 0",
                            sec_en, time_left, paused, running);
      end
      tick(0, 0, 1);
   endtask

   task automatic test_clear_terminal();
      tick(1, 0, 0);
      for (int e = 1; e <= 29; e++) tick(0, 0, 0);
      tick(0, 0, 1);
      n_checks++;
      if (time_up !== 1'b0 || running !== 1'b0 || done !== 1'b0 || time_left !== 8'(GAME)) begin
         n_fail++; $display("FAIL clear_terminal tu=%b run=%b done=%b tl=%0d exp 0 0 0 %0d",
                            time_up, running, done, time_left, GAME);
      end
      test_countdown("replay");
      tick(0, 0, 1);
   endtask

   task automatic test_ignored_and_async();
      // start during RUN must not restart the countdown
      tick(1, 0, 0);
      for (int e = 1; e <= 10; e++) begin
         tick(e == 3, 0, 0);
         n_checks++;
         if ((obs_vec() & msk()) !== (exp_vec() & msk())) begin
            n_fail++; $display("FAIL start_in_run cyc=%0d obs=%h exp=%h", e, obs_vec(), exp_vec());
         end
      end
      n_checks++;
      if (time_left !== 8'd2) begin
         n_fail++; $display("FAIL start_in_run_tl tl=%0d exp 2", time_left);
      end
      // asynchronous reset between edges
      rst = 1;
      #2;
      n_checks++;
      if (obs_vec() !== {8'b0, 8'(GAME)}) begin
         n_fail++; $display("FAIL async_reset obs=%h exp=%h", obs_vec(), {8'b0, 8'(GAME)});
      end
      @(posedge clk); #1;
      rst = 0;
      model_reset();
      // pause_toggle in IDLE
      tick(0, 1, 0);
      n_checks++;
      if (paused !== 1'b0 || running !== 1'b0) begin
         n_fail++; $display("FAIL pause_in_idle paused=%b running=%b exp 0 0", paused, running);
      end
      // pause_toggle in DONE
      tick(1, 0, 0);
      for (int e = 1; e <= 30; e++) tick(0, 0, 0);
      tick(0, 1, 0);
      n_checks++;
      if (done !== 1'b1 || paused !== 1'b0 || time_left !== 8'd0) begin
         n_fail++; $display("FAIL pause_in_done done=%b paused=%b tl=%0d exp 1 0 0", done, paused, time_left);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         tick($urandom_range(0, 99) < 4, $urandom_range(0, 99) < 6, $urandom_range(0, 99) < 1);
         n_checks++;
         if ((obs_vec() & msk()) !== (exp_vec() & msk())) begin
            n_fail++; $display("FAIL random cyc=%0d obs=%h exp=%h", i, obs_vec(), exp_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_countdown("countdown");
      tick(0, 0, 1);
      test_pause();
      test_pause_on_tick();
      test_clear_terminal();
      test_ignored_and_async();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/game_tick_scheduler.md
# game_tick_scheduler

Single-clock timebase controller for the game. It replaces derived clocks with one-cycle clock-enable strobes on the master clock: pixel, 7-segment scan, character-move and one-second ticks. It also sequences game time through an IDLE/RUN/PAUSE/DONE state machine with a seconds countdown. The VGA, display, character and game-logic blocks consume its strobes and status; no logic in the design is clocked by anything other than `clk`.

## Interface
Parameters:
- `PIX_DIV`, 4 — master cycles per pixel strobe (25 MHz at 100 MHz).
- `SEG_DIV`, 200000 — cycles per segment-scan strobe (500 Hz).
- `CHAR_DIV`, 10000000 — cycles per character-move strobe (10 Hz).
- `SEC_DIV`, 100000000 — cycles per second strobe (1 Hz).
- `GAME_SECONDS`, 180 — countdown start value; legal range 1 to 2^SEC_W-1.
- `SEC_W`, 8 — width of `time_left`.
- All `*_DIV` values ≥ 2. Divider counters are 32 bits.

Ports:
- `clk` in 1 — 100 MHz master clock.
- `rst` in 1 — asynchronous, active-high reset.
- `start` in 1 — pulse; begins or restarts a game.
- `pause_toggle` in 1 — pulse; RUN↔PAUSE.
- `clear` in 1 — pulse; abort to IDLE.
- `pix_en` out 1 — pixel strobe, free-running.
- `seg_en` out 1 — segment-scan strobe, free-running.
- `char_en` out 1 — character-move strobe, RUN only.
- `sec_en` out 1 — second strobe, RUN only.
- `running` out 1 — state == RUN.
- `paused` out 1 — state == PAUSE.
- `done` out 1 — state == DONE.
- `time_left` out SEC_W — seconds remaining.
- `time_up` out 1 — one-cycle pulse when countdown reaches 0.

## Operation
- Each strobe has a divider counter. When the counter is at DIV-1, the counter wraps to 0 and the strobe is registered high for exactly one cycle. Otherwise the counter increments and the strobe is low.
- `pix_en` and `seg_en` count in every state, so the display refreshes while idle or paused.
- `char_en` and `sec_en` counters depend on state:
  - RUN: the counters increment.
  - PAUSE: the counters hold their value; the strobes are low.
  - IDLE and DONE: the counters are forced to 0; the strobes are low.
- States and transitions. Priority per cycle is `clear` > `start` > `pause_toggle`.
  - IDLE: on `start`, go to RUN. Load `time_left` = GAME_SECONDS and zero the char/sec counters.
  - RUN: on `pause_toggle`, go to PAUSE. On a second tick with `time_left` == 1: `time_left` becomes 0, `time_up` pulses, and the state goes to DONE. Any other second tick decrements `time_left`.
  - PAUSE: on `pause_toggle`, go to RUN. Counters resume from their held values.
  - DONE: on `start`, go to RUN with a reload as in IDLE.
  - Any state: on `clear`, go to IDLE, `time_left` = GAME_SECONDS, char/sec counters = 0.
- `start` in RUN or PAUSE is ignored. `pause_toggle` in IDLE or DONE is ignored.
- Simultaneous second tick and `pause_toggle` in RUN: the tick is honoured (`sec_en` pulses, `time_left` decrements, counter wraps), then the state enters PAUSE. If that tick reaches 0, the state goes to DONE and the pause is dropped.
- Simultaneous `clear` and a terminal tick: `clear` wins. No `time_up` pulse; `time_left` = GAME_SECONDS.
- `time_left` never underflows. It is 0 only in DONE.

## Timing
- Reset values:
  - State IDLE.
  - All divider counters 0.
  - `pix_en`, `seg_en`, `char_en`, `sec_en`, `time_up` = 0.
  - `running`, `paused`, `done` = 0.
  - `time_left` = GAME_SECONDS.
- Reset asserted mid-game returns every output to its reset value immediately. It does not wait for a clock edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- After reset release, `pix_en` first rises PIX_DIV edges later and then has period PIX_DIV. The same applies to `seg_en` with SEG_DIV.
- With `start` sampled at edge E0:
  - `running` is high after E0.
  - `sec_en` first rises after edge E0+SEC_DIV.
  - `char_en` first rises after edge E0+CHAR_DIV.
- `time_left` updates on the same edge that raises `sec_en`.
- On the terminal tick, the same edge raises `sec_en` and `time_up`, sets `time_left` = 0, and moves the state to DONE (`running`=0, `done`=1).
- A pause of P cycles delays every subsequent char/sec strobe by exactly P cycles.

## Test plan
Bench parameters: PIX_DIV=4, SEG_DIV=5, CHAR_DIV=3, SEC_DIV=10, GAME_SECONDS=3.

1. Reset, then 40 idle cycles -> `pix_en` pulses every 4 cycles; `seg_en` every 5; `char_en`/`sec_en` never; `time_left`=3; `running`=0.
2. `start` at E0 -> `sec_en` after E10, E20, E30; `time_left` 2, 1, 0. At E30: `time_up` one cycle, `done`=1, `running`=0. No further `sec_en`.
3. `start` at E0, `pause_toggle` at E4, `pause_toggle` at E24 -> first `sec_en` after E30 (20-cycle delay). `paused`=1 for E4–E23.
4. `pause_toggle` on the edge that raises the first `sec_en` -> `time_left`=2 and `paused`=1 on the same edge.
5. `clear` coincident with the terminal tick -> no `time_up`; state IDLE; `time_left`=3. A subsequent `start` replays scenario 2.
6. `rst` pulsed mid-RUN between edges -> outputs return to reset values without a clock edge. `start` in RUN and `pause_toggle` in IDLE/DONE cause no state change.
